pkt_rr_arbiter: RTL and testbench
=================================

# pkt_rr_arbiter

Round-robin packet arbiter that shares the single transaction input port of the design under test among `N_REQ` requesters. Each requester offers a packet of `req_len` words, length 1..15, matching the transaction item's `length >= 1` rule. The block grants one requester at a time and forwards exactly `req_len` data words with first/last framing. It then rotates priority. It sits between the stimulus-side requesters and `dut`, and owns the packet-boundary state machine.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: data word width.
- `LEN_W`, 4: packet length field width. Maximum packet is 2^LEN_W−1 words.

- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset. It is synchronous and active-high.
- `req_valid`, in, N_REQ: requester i has a word or packet pending.
- `req_len`, in, N_REQ*LEN_W: length of requester i's packet, in slice `[i*LEN_W +: LEN_W]`. Sampled only at grant.
- `req_data`, in, N_REQ*DATA_W: current word of requester i, in slice `[i*DATA_W +: DATA_W]`.
- `req_ready`, out, N_REQ: word from requester i is accepted when `req_valid[i] & req_ready[i]`.
- `out_valid`, out, 1: word valid toward the DUT.
- `out_data`, out, DATA_W: forwarded word.
- `out_first`, out, 1: marks the first word of a packet.
- `out_last`, out, 1: marks the last word of a packet.
- `out_ready`, in, 1: DUT accepts the word.
- `grant`, out, N_REQ: one-hot current owner. All zero when idle.
- `busy`, out, 1: high while in XFER.
- `err_len`, out, 1: one-cycle pulse when a zero-length packet is granted.

## Operation
- Registered state:
  - FSM: IDLE, XFER.
  - Round-robin pointer `ptr`: $clog2(N_REQ) bits.
  - Grant register.
  - Remaining-word counter `cnt`: LEN_W bits.
  - `first` flag.
- IDLE:
  - Winner is the first i with `req_valid[i]`, searched in order ptr, ptr+1, …, N_REQ−1, 0, …, ptr−1.
  - No valid requester: stay in IDLE.
  - Winner with `req_len` ≠ 0: on the next edge, load grant with the one-hot winner, load `cnt = req_len[winner]`, set `first = 1`, go to XFER.
  - Winner with `req_len` = 0: no grant. `err_len` = 1 for that one cycle. `ptr` = winner+1 mod N_REQ. Stay in IDLE. No word is consumed.
- XFER, granted index g:
  - `out_valid = req_valid[g]`.
  - `out_data = req_data[g]`.
  - `req_ready[g] = out_ready`; every other `req_ready` bit is 0.
  - `out_first = first & out_valid`.
  - `out_last = (cnt == 1) & out_valid`.
  - Transfer condition: `out_valid & out_ready`. On each transfer, `cnt` decrements and `first` clears.
  - Transfer with `cnt == 1`: clear grant, set `ptr` = g+1 mod N_REQ, go to IDLE.
  - `req_valid[g]` low mid-packet: stall. Grant is held, `cnt` is unchanged, `out_valid` = 0. There is no timeout.
  - Non-granted `req_valid` bits are ignored until IDLE.
- Outputs `out_*` and `req_ready` are combinational from registered state plus inputs. In IDLE, `out_valid`, `out_first`, `out_last`, `req_ready` and `busy` are all 0.
- Counter never wraps: XFER is entered only with `cnt` ≥ 1, and it exits on the `cnt == 1` transfer.

## Timing
- Reset values, applied on the clock edge with `rst` = 1:
  - state = IDLE, `ptr` = 0, grant = 0, `cnt` = 0, `first` = 0.
  - Hence `busy` = 0, `out_valid` = 0, `req_ready` = 0, `err_len` = 0.
- Reset mid-packet: the partial packet is abandoned with no `out_last`. In the first cycle after reset, all outputs are idle. Arbitration restarts from requester 0.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge k gives grant/`busy` high after edge k. The first word can transfer in that same cycle.
- A packet of L words with no stalls occupies L cycles of XFER plus 1 IDLE arbitration cycle. Sustained throughput is L/(L+1).
- `out_data` is stable and held while `out_valid & !out_ready`, because the requester holds it per its handshake.
- With L = 1, `out_first` and `out_last` are asserted in the same cycle.
- `err_len` is asserted only in IDLE, and never in the same cycle as `out_valid`.

## Test plan
- Reset: drive `rst` for 2 cycles with all `req_valid` = 1. Required: `grant` = 0, `out_valid` = 0, `busy` = 0, `err_len` = 0 throughout, and the first grant after release is 4'b0001.
- Single packet: requester 1, `req_len` = 3, words 0xA, 0xB, 0xC, `out_ready` = 1. Required: `grant` = 4'b0010 one cycle after `req_valid`. Words 0xA, 0xB, 0xC appear on consecutive cycles, with `out_first` on 0xA and `out_last` on 0xC. Then one IDLE cycle with `busy` = 0.
- Fairness: all 4 requesters continuously valid, length 1 each. Required: grant order 0, 1, 2, 3, 0, 1, with one word every 2 cycles.
- Backpressure and starvation: requester 2, `req_len` = 4. Drop `out_ready` for 2 cycles after word 2, and drop `req_valid[2]` for 1 cycle after word 3. Required: `out_data` held stable, `req_ready[2]` = 0 during the `out_ready` stall, exactly 4 transfers, `out_last` only on word 4.
- Zero length: requester 2 offers `req_len` = 0 and requester 3 offers `req_len` = 2, with `ptr` = 2. Required: `err_len` pulses for one cycle, no `out_valid` for requester 2, next grant = 4'b1000, and 2 words forwarded.
- Max length and mid-packet reset: requester 0, `req_len` = 15. Required: exactly 15 transfers, `out_last` on the 15th. Repeat and assert `rst` after 5 words. Required: next cycle idle, no `out_last`, and re-grant to requester 0.

Source files
------------

// File: rtl/pkt_rr_arbiter.sv
// rtl/pkt_rr_arbiter.sv - round-robin packet arbiter forwarding req_len words per grant with first/last framing
module pkt_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_first,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    err_len
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             win_found;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W-1:0] cnt;
    logic             first;
    logic             take_grant;
    logic             zero_len;
    logic             xfer_fire;
    logic             last_fire;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + PTR_W'(1);
    endfunction

    // Search order starts at ptr and wraps, so the last-served requester goes to the back.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    assign win_len    = req_len[int'(win)*LEN_W +: LEN_W];
    assign take_grant = (state == IDLE) && win_found && (win_len != '0);
    assign zero_len   = (state == IDLE) && win_found && (win_len == '0);
    assign xfer_fire  = out_valid & out_ready;
    assign last_fire  = xfer_fire && (cnt == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_grant) state_nxt = XFER;
            XFER:    if (last_fire)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = req_data[int'(gidx)*DATA_W +: DATA_W];
        out_first = 1'b0;
        out_last  = 1'b0;
        req_ready = '0;
        busy      = 1'b0;
        err_len   = 1'b0;
        case (state)
            IDLE: err_len = zero_len;
            XFER: begin
                busy            = 1'b1;
                out_valid       = req_valid[gidx];
                out_first       = first & out_valid;
                out_last        = (cnt == LEN_W'(1)) & out_valid;
                req_ready[gidx] = out_ready;
            end
            default: ;
        endcase
    end

    // A zero-length winner is skipped by moving ptr past it without consuming anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            grant <= '0;
            gidx  <= '0;
            cnt   <= '0;
            first <= 1'b0;
        end else if (state == IDLE) begin
            if (take_grant) begin
                grant <= N_REQ'(1) << win;
                gidx  <= win;
                cnt   <= win_len;
                first <= 1'b1;
            end else if (zero_len) begin
                ptr <= next_idx(win);
            end
        end else if (xfer_fire) begin
            cnt   <= cnt - LEN_W'(1);
            first <= 1'b0;
            if (cnt == LEN_W'(1)) begin
                grant <= '0;
                ptr   <= next_idx(gidx);
            end
        end
    end
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb/tb_pkt_rr_arbiter.sv - directed bench for pkt_rr_arbiter with a per-cycle packet-level model
module tb_pkt_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_first;
    logic            out_last;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            busy;
    logic            err_len;

    bit              tv[N];
    logic [LW-1:0]   tl[N];
    logic [DW-1:0]   td[N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_valid[gi]           = tv[gi];
        assign req_len[gi*LW +: LW]    = tl[gi];
        assign req_data[gi*DW +: DW]   = td[gi];
    end

    pkt_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int err_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int            c;
        logic [N-1:0]  g;
        logic [DW-1:0] d;
        logic          f;
        logic          l;
    } xfer_t;
    xfer_t log_q[$];

    // Packet-level model: who owns the port, how many words are left, where the search starts.
    bit m_ok    = 1'b0;
    bit m_busy  = 1'b0;
    bit m_first = 1'b0;
    int m_owner = 0;
    int m_left  = 0;
    int m_ptr   = 0;

    function automatic int winner(input int p);
        for (int k = 0; k < N; k++)
            if (tv[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] e_g;
        logic [N-1:0] e_rdy;
        logic         e_v;
        logic         e_f;
        logic         e_l;
        logic         e_e;
        int           w;
        xfer_t        x;
        if (m_ok) begin
            w     = winner(m_ptr);
            e_g   = m_busy ? (N'(1) << m_owner) : '0;
            e_v   = m_busy && tv[m_owner];
            e_f   = e_v && m_first;
            e_l   = e_v && (m_left == 1);
            e_rdy = (m_busy && out_ready) ? e_g : '0;
            e_e   = !m_busy && (w >= 0) && (tl[w] == '0);
            check("outputs", 64'({grant, req_ready, busy, out_valid, out_first, out_last, err_len}),
                  64'({e_g, e_rdy, m_busy, e_v, e_f, e_l, e_e}));
            if (e_v) check("out_data", 64'(out_data), 64'(td[m_owner]));
        end
        if (!rst && out_valid && out_ready) begin
            x.c = cyc; x.g = grant; x.d = out_data; x.f = out_first; x.l = out_last;
            log_q.push_back(x);
        end
        if (err_len) err_seen++;
        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_first = 1'b0; m_left = 0; m_ptr = 0;
        end else if (m_ok) begin
            if (!m_busy) begin
                w = winner(m_ptr);
                if (w >= 0) begin
                    if (tl[w] == '0) begin
                        m_ptr = (w + 1) % N;
                    end else begin
                        m_busy = 1'b1; m_owner = w; m_left = int'(tl[w]); m_first = 1'b1;
                    end
                end
            end else if (tv[m_owner] && out_ready) begin
                m_first = 1'b0;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0; tl[i] = '0; td[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
        err_seen = 0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b1; tl[i] = 4'd1; td[i] = 32'h40 + 32'(i);
        end

        // Reset held two cycles with every requester valid
        tick();
        check("reset_grant", 64'(grant), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        check("reset_first_grant", 64'(grant), 64'(4'b0001));
        tick();
        clear_reqs();
        tick();

        // Single 3-word packet from requester 1
        do_reset();
        tv[1] = 1'b1; tl[1] = 4'd3; td[1] = 32'hA;
        #1 check("single_pre_grant", 64'(grant), 64'(0));
        tick();
        check("single_grant", 64'(grant), 64'(4'b0010));
        tick();
        td[1] = 32'hB;
        tick();
        td[1] = 32'hC;
        #1 check("single_last_flag", 64'({out_valid, out_first, out_last}), 64'(3'b101));
        tick();
        tv[1] = 1'b0;
        #1 check("single_idle_after", 64'(busy), 64'(0));
        check("single_count", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) begin
            check("single_w0", 64'({log_q[0].d, log_q[0].f, log_q[0].l}), 64'({32'hA, 2'b10}));
            check("single_w1", 64'({log_q[1].d, log_q[1].f, log_q[1].l}), 64'({32'hB, 2'b00}));
            check("single_w2", 64'({log_q[2].d, log_q[2].f, log_q[2].l}), 64'({32'hC, 2'b01}));
            check("single_back_to_back", 64'(log_q[2].c - log_q[0].c), 64'(2));
        end

        // Fairness: all requesters valid, length 1
        do_reset();
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b1; tl[i] = 4'd1; td[i] = 32'h10 + 32'(i);
        end
        repeat (12) tick();
        clear_reqs();
        check("fair_count", 64'(log_q.size()), 64'(6));
        for (int k = 0; k < log_q.size() && k < 6; k++) begin
            check("fair_grant", 64'(log_q[k].g), 64'(4'b0001 << (k % 4)));
            check("fair_data", 64'(log_q[k].d), 64'(32'h10 + 32'(k % 4)));
            check("fair_framing", 64'({log_q[k].f, log_q[k].l}), 64'(2'b11));
            if (k > 0) check("fair_spacing", 64'(log_q[k].c - log_q[k-1].c), 64'(2));
        end
        tick();

        // Backpressure and requester stall on a 4-word packet from requester 2
        do_reset();
        tv[2] = 1'b1; tl[2] = 4'd4; td[2] = 32'h21;
        tick();
        tick();
        td[2] = 32'h22;
        tick();
        td[2] = 32'h23;
        out_ready = 1'b0;
        #1 check("bp_stall0", 64'({out_valid, req_ready, out_data}), 64'({1'b1, 4'b0000, 32'h23}));
        tick();
        check("bp_stall1", 64'({out_valid, req_ready, out_data}), 64'({1'b1, 4'b0000, 32'h23}));
        tick();
        out_ready = 1'b1;
        tick();
        tv[2] = 1'b0; td[2] = 32'h24;
        #1 check("bp_req_gap", 64'({out_valid, grant}), 64'({1'b0, 4'b0100}));
        tick();
        tv[2] = 1'b1;
        #1 check("bp_last_word", 64'({out_last, out_data}), 64'({1'b1, 32'h24}));
        tick();
        tv[2] = 1'b0;
        tick();
        check("bp_count", 64'(log_q.size()), 64'(4));
        for (int k = 0; k < log_q.size() && k < 4; k++) begin
            check("bp_data", 64'(log_q[k].d), 64'(32'h21 + 32'(k)));
            check("bp_last", 64'(log_q[k].l), 64'(k == 3));
        end

        // Zero-length packet skipped with ptr at 2
        do_reset();
        tv[1] = 1'b1; tl[1] = 4'd1; td[1] = 32'h55;
        tick();
        tick();
        tv[1] = 1'b0;
        tv[2] = 1'b1; tl[2] = 4'd0;
        tv[3] = 1'b1; tl[3] = 4'd2; td[3] = 32'h31;
        #1 check("zl_err_pulse", 64'({err_len, grant, out_valid}), 64'({1'b1, 4'b0000, 1'b0}));
        tick();
        check("zl_err_gone", 64'({err_len, grant}), 64'({1'b0, 4'b0000}));
        tick();
        check("zl_next_grant", 64'(grant), 64'(4'b1000));
        tv[2] = 1'b0;
        tick();
        td[3] = 32'h32;
        tick();
        tv[3] = 1'b0;
        tick();
        check("zl_err_count", 64'(err_seen), 64'(1));
        check("zl_count", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) begin
            check("zl_w1", 64'({log_q[1].g, log_q[1].d, log_q[1].f}), 64'({4'b1000, 32'h31, 1'b1}));
            check("zl_w2", 64'({log_q[2].g, log_q[2].d, log_q[2].l}), 64'({4'b1000, 32'h32, 1'b1}));
        end

        // Maximum-length packet
        do_reset();
        tv[0] = 1'b1; tl[0] = 4'd15; td[0] = 32'h100;
        tick();
        for (int k = 0; k < 15; k++) begin
            td[0] = 32'h100 + 32'(k);
            tick();
        end
        tv[0] = 1'b0;
        #1 check("max_done_idle", 64'(busy), 64'(0));
        check("max_count", 64'(log_q.size()), 64'(15));
        for (int k = 0; k < log_q.size() && k < 15; k++)
            check("max_word", 64'({log_q[k].d, log_q[k].l}), 64'({32'h100 + 32'(k), k == 14}));
        tick();

        // Same packet again, abandoned by reset after 5 words
        do_reset();
        tv[0] = 1'b1; tl[0] = 4'd15;
        tick();
        for (int k = 0; k < 5; k++) begin
            td[0] = 32'h200 + 32'(k);
            tick();
        end
        td[0] = 32'h205;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check("mid_rst_idle", 64'({grant, busy, out_valid, out_last}), 64'(0));
        tick();
        check("mid_rst_regrant", 64'(grant), 64'(4'b0001));
        check("mid_rst_count", 64'(log_q.size()), 64'(5));
        for (int k = 0; k < log_q.size(); k++)
            check("mid_rst_no_last", 64'(log_q[k].l), 64'(0));
        do_reset();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
